qstate_lane_sched: RTL and testbench

Sequencer for the lane-parallel amplitude datapath. Accepts a command (operation plus beat count), then streams state-vector words through a registered per-lane operation stage using valid/ready handshakes on both sides. Marks the final output beat and pulses `done` when the command completes. Sits between the state-vector memory streamer and the downstream gate pipeline, and owns sequencing of the lane operation.

---
 rtl/qstate_lane_sched.sv | 186 ++++++++++++++++++
 tb/tb_qstate_lane_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qstate_lane_sched.sv
// -----------------------------------------------------------------------------
// qstate_lane_sched
//
// Sequencer for the lane-parallel amplitude datapath. It accepts one command
// (operation + beat count), streams that many state-vector words through a
// registered per-lane operation stage, tags the final output beat with
// out_last and pulses done once the final beat has left.
//
// A word holds 2**n lanes of 2*w bits. Within a lane the upper w bits are the
// real part and the lower w bits are the imaginary part.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command accepted when high (IDLE only)
//   cmd_op     00 pass, 01 NOT lane, 10 NOT imaginary half, 11 lane reverse
//   cmd_len    number of beats in the command (0 completes immediately)
//   in_data    input word
//   in_valid   input word valid
//   in_ready   input accepted when in_valid && in_ready
//   out_data   processed word
//   out_valid  output word valid
//   out_ready  downstream ready
//   out_last   marks the final beat of the command
//   busy       high whenever the sequencer is not idle
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module qstate_lane_sched #(
  parameter  int n      = 3,
  parameter  int w      = 2,
  parameter  int LEN_W  = 16,
  localparam int LANES  = 2**n,
  localparam int LANE_W = 2*w,
  localparam int DATA_W = LANES*LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_NOT  = 2'b01;
  localparam logic [1:0] OP_NIM  = 2'b10;
  localparam logic [1:0] OP_REV  = 2'b11;

  // Mask with the imaginary (low w) bits of every lane set.
  function automatic logic [DATA_W-1:0] imag_mask();
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i*LANE_W +: w] = '1;
    end
    return m;
  endfunction

  // Per-lane operation applied to one word.
  function automatic logic [DATA_W-1:0] lane_op(input logic [1:0]        op,
                                               input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (op)
      OP_PASS: r = d;
      OP_NOT:  r = ~d;
      OP_NIM:  r = d ^ imag_mask();
      OP_REV: begin
        for (int i = 0; i < LANES; i++) begin
          r[i*LANE_W +: LANE_W] = d[(LANES-1-i)*LANE_W +: LANE_W];
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  state_t            state_q;
  logic [1:0]        op_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;

  logic [DATA_W-1:0] out_data_d;
  logic              in_fire;
  logic              out_fire;
  logic              last_beat;

  // The output register may take a new beat when it is empty or being drained
  // in the same cycle, which gives full throughput with out_ready held high.
  assign in_ready   = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign last_beat  = (rem_q == LEN_W'(1));
  assign out_data_d = lane_op(op_q, in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_PASS;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              // Empty command: nothing to stream, complete straight away.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              op_q    <= cmd_op;
              rem_q   <= cmd_len;
              state_q <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (in_fire) begin
            out_data_q  <= out_data_d;
            out_valid_q <= 1'b1;
            out_last_q  <= last_beat;
            rem_q       <= rem_q - LEN_W'(1);
            if (last_beat) begin
              state_q <= S_DRAIN;
            end
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end

        // Only the final beat can be held here: it was loaded into an empty
        // or simultaneously drained register.
        S_DRAIN: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_qstate_lane_sched.sv
module tb_qstate_lane_sched;

  localparam int N     = 3;
  localparam int W     = 2;
  localparam int LEN_W = 16;
  localparam int LANES = 2**N;
  localparam int LW    = 2*W;
  localparam int DW    = LANES*LW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [DW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic             busy;
  logic             done;

  qstate_lane_sched #(.n(N), .w(W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] dq[$];   // directed input words
  logic [DW-1:0] xq[$];   // directed expected words

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  int or_mode = 0;        // 0: out_ready high, 1: random
  bit in_reset = 1'b0;
  bit len0_active = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: treat the word as an array of complex lanes.
  function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] d);
    int lane[LANES];
    int lmax, imax, re, im, v;
    logic [DW-1:0] r;
    lmax = (1 << LW) - 1;
    imax = (1 << W) - 1;
    for (int i = 0; i < LANES; i++) lane[i] = int'((d >> (i*LW)) & DW'(lmax));
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      re = lane[j] / (1 << W);
      im = lane[j] % (1 << W);
      case (op)
        2'b00:   v = lane[j];
        2'b01:   v = lmax - lane[j];
        2'b10:   v = re * (1 << W) + (imax - im);
        default: v = lane[LANES-1-j];
      endcase
      r[j*LW +: LW] = LW'(v);
    end
    return r;
  endfunction

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (or_mode == 1) begin
      out_ready = ($urandom % 4) != 0;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor / scoreboard.
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  bit            last_hs_prev = 1'b0;
  exp_t          e;

  always @(negedge clk) begin
    if (in_reset || !rst_n) begin
      prev_stall   = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow got unexpected beat %0h expected none", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
        end
      end
      if (len0_active) begin
        chk("len0_quiet", {in_ready, out_valid}, 0);
        if (done) len0_active = 1'b0;
      end else if (done || last_hs_prev) begin
        chk("done_timing", done, last_hs_prev);
      end
      if (done) done_cnt++;
      prev_stall   = out_valid && !out_ready;
      prev_data    = out_data;
      prev_last    = out_last;
      last_hs_prev = out_valid && out_ready && out_last;
    end
  end

  // Issue one command and feed `feed` beats; wait for done when fully fed.
  task automatic run_cmd(input logic [1:0] op, input int len, input int feed,
                         input bit gaps, input int stall_after);
    int cyc, start;
    bit fire;
    exp_t x;
    cyc = 0;
    while (!cmd_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    start = done_cnt;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LEN_W'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = $urandom; cmd_len = $urandom;
    chk("busy_after_accept", busy, 1);
    if (len == 0) len0_active = 1'b1;
    for (int b = 0; b < feed; b++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_data  = (dq.size() != 0) ? dq.pop_front() : DW'($urandom);
      in_valid = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk);
        fire = in_ready;
        if (fire) begin
          x.data = (xq.size() != 0) ? xq.pop_front() : model(op, in_data);
          x.last = (b == len - 1);
          sb.push_back(x);
          if (b == stall_after) stall_cnt = 3;
        end
        @(posedge clk); #1;
        cyc++;
      end while (!fire && cyc < 200);
      if (!fire) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      in_data  = $urandom;
    end
    if (feed == len) begin
      cyc = 0;
      while (done_cnt == start && cyc < 300) begin @(negedge clk); #1; cyc++; end
      chk("done_seen", done_cnt - start, 1);
      if (len == 0) chk("len0_done_latency_le2", cyc <= 2, 1);
      @(posedge clk); #1;
      chk("busy_after_done", busy, 0);
      chk("cmd_ready_after_done", cmd_ready, 1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // NOT lane on an all-zero word.
    dq.push_back(32'h0000_0000); xq.push_back(32'hFFFF_FFFF);
    run_cmd(2'b01, 1, 1, 0, -1);

    // NOT imaginary half.
    dq.push_back(32'h0000_0000); xq.push_back(32'h3333_3333);
    dq.push_back(32'hF0F0_F0F0); xq.push_back(32'hC3C3_C3C3);
    run_cmd(2'b10, 2, 2, 0, -1);

    // Lane reverse.
    dq.push_back(32'h0123_4567); xq.push_back(32'h7654_3210);
    run_cmd(2'b11, 1, 1, 0, -1);

    // Pass-through with a 3-cycle downstream stall after the second beat.
    run_cmd(2'b00, 4, 4, 0, 1);

    // Empty command.
    run_cmd(2'b01, 0, 0, 0, -1);

    // Reset in the middle of a 5-beat command after 2 beats.
    run_cmd(2'b01, 5, 2, 0, -1);
    @(posedge clk); #3;
    in_reset = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    sb.delete();
    d0 = done_cnt;
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_reset = 1'b0;
    chk("midreset_no_done_cnt", done_cnt - d0, 0);
    run_cmd(2'b11, 3, 3, 0, -1);

    // Randomized commands with input gaps and downstream backpressure.
    or_mode = 1;
    for (int c = 0; c < 40; c++) begin
      int len;
      len = $urandom_range(0, 8);
      run_cmd(2'($urandom), len, len, 1, -1);
    end
    or_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
